// File: rtl/mmc1_if.sv
// mmc1_if: CPU-side and PPU-side bus bundle between the bus mux / PPU and the MMC1 mapper.
// Ports: a_in/d_in/wr_in (muxed CPU bus), ppu_a_in (PPU VRAM address) in;
//        prg_a_out, prg_ram_en_out, chr_a_out, mirror_out out of the mapper.
interface mmc1_if #(
    parameter int PRG_BANK_BITS = 4,
    parameter int CHR_BANK_BITS = 5
);
    logic [15:0]                  a_in;
    logic [7:0]                   d_in;
    logic                         wr_in;
    logic [13:0]                  ppu_a_in;
    logic [PRG_BANK_BITS+13:0]    prg_a_out;
    logic                         prg_ram_en_out;
    logic [CHR_BANK_BITS+11:0]    chr_a_out;
    logic [1:0]                   mirror_out;

    // Bus side: drives the CPU/PPU addresses and observes the mapper outputs.
    modport master (
        output a_in, d_in, wr_in, ppu_a_in,
        input  prg_a_out, prg_ram_en_out, chr_a_out, mirror_out
    );

    // Mapper side.
    modport slave (
        input  a_in, d_in, wr_in, ppu_a_in,
        output prg_a_out, prg_ram_en_out, chr_a_out, mirror_out
    );
endinterface

// File: rtl/mmc1.sv
// mmc1: MMC1 (SxROM) mapper - serial 5-bit register loads at $8000-$FFFF, PRG/CHR banking, mirroring.
// Ports: clk_in, rst_in (sync, active-high); bus (mmc1_if.slave) carries CPU/PPU addresses and
//        the translated prg_a_out/chr_a_out, prg_ram_en_out and mirror_out (combinational from registers).
module mmc1 #(
    parameter int PRG_BANK_BITS = 4,
    parameter int CHR_BANK_BITS = 5
) (
    input  logic         clk_in,
    input  logic         rst_in,
    mmc1_if.slave        bus
);
    localparam int PB = PRG_BANK_BITS;
    localparam int CB = CHR_BANK_BITS;

    logic [4:0] shift_q,   shift_d;
    logic [2:0] cnt_q,     cnt_d;
    logic [4:0] control_q, control_d;
    logic [4:0] chr0_q,    chr0_d;
    logic [4:0] chr1_q,    chr1_d;
    logic [4:0] prg_q,     prg_d;
    logic       wr_q;

    logic       wr_qual;
    logic       wr_evt;
    logic [4:0] load_val;

    // Only writes to $8000-$FFFF are mapper writes; a held strobe counts once (edge on the
    // qualified strobe), so a write elsewhere also re-arms the edge detector.
    assign wr_qual  = bus.wr_in & bus.a_in[15];
    assign wr_evt   = wr_qual & ~wr_q;
    // Bits arrive LSB first; the fifth bit lands in the MSB.
    assign load_val = {bus.d_in[0], shift_q[4:1]};

    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        control_d = control_q;
        chr0_d    = chr0_q;
        chr1_d    = chr1_q;
        prg_d     = prg_q;
        if (wr_evt) begin
            if (bus.d_in[7]) begin
                // Abort any partial load and force PRG mode 3 (fixed last bank at $C000).
                shift_d        = '0;
                cnt_d          = '0;
                control_d[3:2] = 2'b11;
            end else if (cnt_q != 3'd4) begin
                shift_d = load_val;
                cnt_d   = cnt_q + 3'd1;
            end else begin
                unique case (bus.a_in[14:13])
                    2'd0: control_d = load_val;
                    2'd1: chr0_d    = load_val;
                    2'd2: chr1_d    = load_val;
                    2'd3: prg_d     = load_val;
                endcase
                shift_d = '0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            control_q <= 5'b01100;
            chr0_q    <= '0;
            chr1_q    <= '0;
            prg_q     <= '0;
            wr_q      <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            control_q <= control_d;
            chr0_q    <= chr0_d;
            chr1_q    <= chr1_d;
            prg_q     <= prg_d;
            wr_q      <= wr_qual;
        end
    end

    // PRG banking: modes 0/1 switch 32 KB (bank LSB from the CPU A14), mode 2 fixes the
    // first bank at $8000, mode 3 fixes the last bank at $C000.
    logic [PB-1:0] prg_bank;
    always_comb begin
        prg_bank = '0;
        unique case (control_q[3:2])
            2'd2:    prg_bank = bus.a_in[14] ? prg_q[PB-1:0] : '0;
            2'd3:    prg_bank = bus.a_in[14] ? '1 : prg_q[PB-1:0];
            default: prg_bank = {prg_q[PB-1:1], bus.a_in[14]};
        endcase
    end

    assign bus.prg_a_out      = {prg_bank, bus.a_in[13:0]};
    assign bus.prg_ram_en_out = (bus.a_in[15:13] == 3'b011) & ~prg_q[4];
    assign bus.mirror_out     = control_q[1:0];

    // CHR banking: 8 KB mode ignores chr0 bit 0 and chr1; 4 KB mode selects by PPU A12.
    always_comb begin
        if (control_q[4]) begin
            bus.chr_a_out = {(bus.ppu_a_in[12] ? chr1_q[CB-1:0] : chr0_q[CB-1:0]),
                             bus.ppu_a_in[11:0]};
        end else begin
            bus.chr_a_out = {chr0_q[CB-1:1], bus.ppu_a_in[12:0]};
        end
    end

    // Data bits 6:1 carry nothing for the mapper; PPU A13 ($2000+) is nametable space.
    logic unused_bits;
    assign unused_bits = ^{bus.d_in[6:1], bus.ppu_a_in[13]};
endmodule
